// File: rtl/id_hazard_ctrl_if.sv
// ID-stage hazard controller bundle: IF/ID operands, EX/MEM producers, stall/flush controls, counters.
// No latency of its own; pure wiring between the pipeline and id_hazard_ctrl.
// No backpressure: ext_stall is carried as an ordinary input signal.
interface id_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Instruction currently in IF/ID
    logic             if_id_valid;
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_is_branch;
    logic             id_branch_taken;

    // Producers further down the pipe
    logic             id_ex_RegWrite;
    logic             id_ex_MemRead;
    logic [4:0]       id_ex_rd;
    logic             ex_mem_MemRead;
    logic [4:0]       ex_mem_rd;

    logic             ext_stall;

    // Pipeline control back to IF/ID
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             stalled;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    // Pipeline side: drives hazard inputs, receives controls
    modport master (
        output if_id_valid, if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2,
               id_is_branch, id_branch_taken, id_ex_RegWrite, id_ex_MemRead,
               id_ex_rd, ex_mem_MemRead, ex_mem_rd, ext_stall,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, stalled,
               stall_cycles, flush_count
    );

    // Controller side
    modport slave (
        input  if_id_valid, if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2,
               id_is_branch, id_branch_taken, id_ex_RegWrite, id_ex_MemRead,
               id_ex_rd, ex_mem_MemRead, ex_mem_rd, ext_stall,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, stalled,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard/stall controller with taken-branch flush and saturating event counters.
// Controls are combinational from state+inputs (0-cycle); state and counters update on the clock edge.
// ext_stall freezes everything: no bubble, no flush, state/rem/counters held.
module id_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    id_hazard_ctrl_if.slave   hz
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [0:0]       r_state;
    logic             r_rem;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_ex_match;
    logic             w_mem_match;
    logic             w_need2;
    logic             w_need1;
    logic [1:0]       w_need;
    logic             w_in_run;
    logic             w_stall_cyc;
    logic             w_flush_cyc;
    logic             w_pc_write;
    logic             w_if_id_write;
    logic             w_bubble;
    logic             w_flush;

    // Source-vs-producer matches; x0 never creates a dependency
    always_comb begin
        w_ex_match  = hz.if_id_valid &&
                      ((hz.id_uses_rs1 && (hz.if_id_rs1 != 5'd0) && (hz.if_id_rs1 == hz.id_ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.if_id_rs2 != 5'd0) && (hz.if_id_rs2 == hz.id_ex_rd)));
        w_mem_match = hz.if_id_valid &&
                      ((hz.id_uses_rs1 && (hz.if_id_rs1 != 5'd0) && (hz.if_id_rs1 == hz.ex_mem_rd)) ||
                       (hz.id_uses_rs2 && (hz.if_id_rs2 != 5'd0) && (hz.if_id_rs2 == hz.ex_mem_rd)));
    end

    // Required bubble count: branches read operands in ID so they need more slack than ALU ops
    always_comb begin
        w_need2 = hz.id_is_branch && w_ex_match && hz.id_ex_MemRead;
        w_need1 = (!hz.id_is_branch && w_ex_match && hz.id_ex_MemRead) ||
                  (hz.id_is_branch && w_ex_match && hz.id_ex_RegWrite && !hz.id_ex_MemRead) ||
                  (hz.id_is_branch && w_mem_match && hz.ex_mem_MemRead);
        if (w_need2) begin
            w_need = 2'd2;
        end else if (w_need1) begin
            w_need = 2'd1;
        end else begin
            w_need = 2'd0;
        end
    end

    // Cycle classification; while reset is low the decode behaves as if in RUN
    always_comb begin
        w_in_run    = (r_state == ST_RUN) || !rst_n;
        w_stall_cyc = !hz.ext_stall && (!w_in_run || (w_need != 2'd0));
        w_flush_cyc = !hz.ext_stall && w_in_run && (w_need == 2'd0) &&
                      hz.if_id_valid && hz.id_is_branch && hz.id_branch_taken;
    end

    // Pipeline control decode: freeze > stall > flush > normal
    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;
        if (hz.ext_stall) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
        end else if (w_stall_cyc) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
        end else if (w_flush_cyc) begin
            w_flush       = 1'b1;
        end
    end

    // RUN/STALL sequencing; only a 2-bubble hazard needs the extra STALL cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_rem   <= 1'b0;
        end else if (!hz.ext_stall) begin
            if (r_state == ST_RUN) begin
                if (w_need == 2'd2) begin
                    r_state <= ST_STALL;
                    r_rem   <= 1'b1;
                end
            end else begin
                r_rem <= r_rem - 1'b1;
                if (r_rem == 1'b1) begin
                    r_state <= ST_RUN;
                end
            end
        end
    end

    // Saturating event counters; frozen cycles count nothing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_cyc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_cyc && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign hz.pc_write     = w_pc_write;
    assign hz.if_id_write  = w_if_id_write;
    assign hz.id_ex_bubble = w_bubble;
    assign hz.if_id_flush  = w_flush;
    assign hz.stalled      = (r_state == ST_STALL);
    assign hz.stall_cycles = r_stall_cnt;
    assign hz.flush_count  = r_flush_cnt;

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

ID-stage hazard and stall controller for the 5-stage pipeline with branch resolution in ID. It watches the instruction in IF/ID against the producers in ID/EX and EX/MEM. It decides how many bubble cycles are needed before the ID-stage forwarding paths can supply valid operands, and sequences those stalls with a small FSM. It also generates the IF/ID flush for taken branches and keeps saturating stall/flush event counters.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- if_id_valid  in  1  IF/ID holds a real instruction
- if_id_rs1, if_id_rs2  in  5  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- id_is_branch  in  1  ID instruction is branch/JALR (operands consumed in ID)
- id_branch_taken  in  1  ID-stage comparison result, meaningful only when no stall
- id_ex_RegWrite, id_ex_MemRead  in  1  controls of instruction in EX
- id_ex_rd  in  5  destination of instruction in EX
- ex_mem_MemRead  in  1  instruction in MEM is a load
- ex_mem_rd  in  5  destination of instruction in MEM
- ext_stall  in  1  external freeze (memory not ready)
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID may update
- id_ex_bubble  out  1  insert NOP into ID/EX
- if_id_flush  out  1  squash IF/ID (taken branch)
- stalled  out  1  high while FSM is in STALL
- stall_cycles  out  CNT_W  hazard-stall cycles, saturating
- flush_count  out  CNT_W  taken-branch flushes, saturating

## Operation
- Match terms ignore rd==0. A match also requires if_id_valid and the relevant id_uses_rsX. An "EX match" is a match against id_ex_rd; a "MEM match" is a match against ex_mem_rd.
- Required stall N, evaluated in RUN:
  - Non-branch, EX match with id_ex_MemRead: N=1 (load-use).
  - Branch, EX match with id_ex_MemRead: N=2.
  - Branch, EX match with id_ex_RegWrite and no MemRead: N=1.
  - Branch, MEM match with ex_mem_MemRead: N=1.
  - Otherwise N=0. When several rules apply, the maximum N is taken.
- FSM states are RUN and STALL, with a 1-bit remaining counter `rem`.
  - RUN with N>0 and no ext_stall: stall this cycle. If N==2, load rem=1 and go to STALL; if N==1, stay in RUN.
  - STALL without ext_stall: stall this cycle, rem decrements, go to RUN when rem reaches 0. Hazard inputs are ignored in STALL.
  - ext_stall in any state holds state and rem.
- Stall cycle outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
- ext_stall outputs override everything: pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0. No counter increments.
- Flush: in RUN, with N==0, no ext_stall, if_id_valid, id_is_branch and id_branch_taken, drive if_id_flush=1 and pc_write=1. flush_count increments.
- Normal cycles: pc_write=1, if_id_write=1, all others 0.
- stall_cycles increments on every stall cycle. Both counters saturate at all-ones.
- stalled=1 exactly when state==STALL.

## Timing
- Stall and flush outputs are combinational from the current state and inputs, taking effect in the same cycle a hazard is detected.
- The FSM state and counters are registered.
- Reset (rst_n low at an edge) sets state=RUN, rem=0 and both counters to 0. During reset, outputs follow the RUN decode.
- Reset asserted mid-STALL returns the FSM to RUN at the next edge; the remaining stall is abandoned.
- Latency:
  - Load → dependent branch: 2 bubble cycles, then the branch resolves with forwarding from MEM/WB.
  - ALU → branch: 1 bubble.
  - Load → ALU use: 1 bubble.
- A taken branch and a hazard in the same cycle: the stall wins and no flush occurs. The flush is re-evaluated once operands are valid.
- ext_stall during STALL: rem is held, so the total number of bubble cycles is unchanged; only the elapsed wall time grows.

## Test plan
- Load x5 in EX, ALU in ID reads x5 → one cycle with id_ex_bubble=1 and pc_write=0; next cycle normal; stall_cycles=1.
- Load x5 in EX, branch in ID reads x5 → stalled=1 on the second cycle, two bubble cycles, then back in RUN; stall_cycles=2.
- ALU writes x7 in EX, branch reads x7 → exactly 1 bubble. Then with id_branch_taken=1: if_id_flush=1, flush_count=1.
- Load writes x0 in EX, branch reads x0 → no stall; id_uses_rs1=0 with a matching rs1 → no stall.
- Load→branch hazard with ext_stall=1 for 3 cycles in mid-STALL → exactly 2 bubble cycles in total; counters are not incremented during the freeze.
- Force stall_cycles to all-ones (2^CNT_W−1) via a long hazard sequence, then cause one more stall → the value holds. rst_n=0 during STALL → RUN and counters 0 after the edge.
